// File: rtl/i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// i2c_target_regfile
//
// I2C target with an internal 2**AW x 8 register file. SCL and SDA are
// oversampled on clk through 2-flop synchronizers plus a history flop. Every
// bus event (SCL rise/fall, START, STOP) is decided from the synchronized
// copies only. SDA is driven through an open-drain enable: 1 pulls low.
//
// Transaction flow:
//   START -> address byte -> ACK
//   write: memory-address byte -> ACK -> data bytes (each ACKed)
//   read : data bytes returned from mem[pointer], master ACK/NACK after each
//
// Ports
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   scl      in   bus clock from the master
//   sda_in   in   bus data as seen on the pin
//   sda_oe   out  1 = pull SDA low, 0 = release
//   busy     out  high from START until STOP or reset
//   wr_en    out  one-clk pulse per data byte written
//   wr_addr  out  register index written (valid with wr_en)
//   wr_data  out  byte written (valid with wr_en)
//   state    out  current FSM state, for debug
//
// Write-side handshake: wr_en is a single-cycle valid qualifier for
// wr_addr/wr_data. There is no ready; the consumer must take the byte in
// the cycle wr_en is high. wr_addr/wr_data hold their last value otherwise.
// ---------------------------------------------------------------------------
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h5B,
  parameter int          AW         = 4,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [3:0]    state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_MADDR     = 4'd3,
    S_MADDR_ACK = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_WAIT_STOP = 4'd9
  } state_t;

  // Synchronizers and history flops. They reset to 1 (idle bus level) so
  // that leaving reset on an idle bus creates no false edge.
  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  state_t          r_state;
  logic [3:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_tx;
  logic            r_rw;
  logic [AW-1:0]   r_ptr;
  logic [7:0]      r_mem [2**AW];
  logic            r_sda_oe;
  logic            r_busy;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [7:0]      r_wr_data;

  logic            w_scl_rise;
  logic            w_scl_fall;
  logic            w_start;
  logic            w_stop;
  logic            w_byte_done;
  logic [2:0]      w_bit_idx;
  logic [2:0]      w_tx_next_idx;
  logic [7:0]      w_next_byte;
  logic [6:0]      w_addr_field;
  logic            w_rw;
  logic [7:0]      w_rd_byte;
  logic            w_first_bit;
  logic            w_tx_next_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // START/STOP need SCL high on both the current and the previous sample, so
  // an SDA change that lands together with an SCL edge is never mistaken
  // for a bus condition.
  assign w_start = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop  = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  // Receive side: byte position of the current wire bit.
  assign w_byte_done = (r_bit_cnt == 4'd7);
  assign w_bit_idx   = LSB_FIRST ? r_bit_cnt[2:0] : (3'd7 - r_bit_cnt[2:0]);

  // Byte as it will look once the bit being sampled now is included.
  always_comb begin
    w_next_byte            = r_shift;
    w_next_byte[w_bit_idx] = r_sda_s2;
  end

  // Wire bits 1-7 carry the address, wire bit 8 carries R/W.
  assign w_addr_field = LSB_FIRST ? w_next_byte[6:0] : w_next_byte[7:1];
  assign w_rw         = LSB_FIRST ? w_next_byte[7]   : w_next_byte[0];

  // Transmit side: r_bit_cnt is the index of the bit currently driven, so
  // at each SCL fall the next wire bit is r_bit_cnt + 1.
  assign w_rd_byte     = r_mem[r_ptr];
  assign w_first_bit   = LSB_FIRST ? w_rd_byte[0] : w_rd_byte[7];
  assign w_tx_next_idx = LSB_FIRST ? (r_bit_cnt[2:0] + 3'd1) : (3'd6 - r_bit_cnt[2:0]);
  assign w_tx_next_bit = r_tx[w_tx_next_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_tx      <= 8'h00;
      r_rw      <= 1'b0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'h00;
      for (int i = 0; i < 2**AW; i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      r_wr_en <= 1'b0;
      if (w_start) begin
        // START or repeated START: the pointer is deliberately kept.
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
      end else if (w_stop) begin
        // Any partially received byte is dropped here without a write.
        r_state   <= S_IDLE;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_next_byte;
              if (w_byte_done) begin
                r_bit_cnt <= 4'd0;
                r_rw      <= w_rw;
                r_state   <= (w_addr_field == SLAVE_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          // ACK slot: the first SCL fall after the 8th bit starts driving
          // low, the fall ending the 9th pulse releases and moves on. The
          // enable itself tells which of the two falls this is.
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else if (r_rw) begin
                r_tx      <= w_rd_byte;
                r_sda_oe  <= ~w_first_bit;
                r_bit_cnt <= 4'd0;
                r_state   <= S_RDATA;
              end else begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= S_MADDR;
              end
            end
          end

          S_MADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_next_byte;
              if (w_byte_done) begin
                r_ptr     <= w_next_byte[AW-1:0];
                r_bit_cnt <= 4'd0;
                r_state   <= S_MADDR_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          S_MADDR_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_sda_oe) begin
                r_sda_oe <= 1'b1;
              end else begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= S_WDATA;
              end
            end
          end

          S_WDATA: begin
            if (w_scl_rise) begin
              r_shift <= w_next_byte;
              if (w_byte_done) begin
                r_wr_en      <= 1'b1;
                r_wr_addr    <= r_ptr;
                r_wr_data    <= w_next_byte;
                r_mem[r_ptr] <= w_next_byte;
                r_ptr        <= r_ptr + AW'(1);
                r_bit_cnt    <= 4'd0;
                r_state      <= S_WDATA_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          // Drive the inverted data bit (open drain: 1 on the wire means
          // release). After the 8th bit the line is released for the
          // master's ACK/NACK.
          S_RDATA: begin
            if (w_scl_fall) begin
              if (w_byte_done) begin
                r_sda_oe  <= 1'b0;
                r_ptr     <= r_ptr + AW'(1);
                r_bit_cnt <= 4'd0;
                r_state   <= S_RDATA_ACK;
              end else begin
                r_sda_oe  <= ~w_tx_next_bit;
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end

          // r_bit_cnt == 1 records that the master ACKed on the 9th rise;
          // the next byte is loaded on the following fall.
          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              if (r_sda_s2) begin
                r_state <= S_WAIT_STOP;
              end else begin
                r_bit_cnt <= 4'd1;
              end
            end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
              r_tx      <= w_rd_byte;
              r_sda_oe  <= ~w_first_bit;
              r_bit_cnt <= 4'd0;
              r_state   <= S_RDATA;
            end
          end

          S_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end

          default: begin
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe  = r_sda_oe;
  assign busy    = r_busy;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign state   = r_state;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regfile
//
// Two targets share one bus: u_dut_lsb (address 5B, LSB first) and
// u_dut_msb (address 3C, MSB first). Each ignores the other's traffic.
// Writes and reads are predicted from a small register-file model. Expected
// values are queued when stimulus is driven and compared when the DUT
// produces them.
// ---------------------------------------------------------------------------
module tb_i2c_target_regfile;

  localparam int Q = 40;  // quarter SCL period; SCL high/low = 8 clk each

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic scl;
  logic m_sda;
  logic sda_bus;

  logic       oe_a, busy_a, wr_en_a;
  logic [3:0] wr_addr_a, state_a;
  logic [7:0] wr_data_a;
  logic       oe_b, busy_b, wr_en_b;
  logic [3:0] wr_addr_b, state_b;
  logic [7:0] wr_data_b;

  // Open-drain wired-AND of the master and both targets.
  assign sda_bus = m_sda & ~oe_a & ~oe_b;

  i2c_target_regfile #(.SLAVE_ADDR(7'h5B), .AW(4), .LSB_FIRST(1'b1)) u_dut_lsb (
    .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_bus),
    .sda_oe(oe_a), .busy(busy_a), .wr_en(wr_en_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .state(state_a)
  );

  i2c_target_regfile #(.SLAVE_ADDR(7'h3C), .AW(4), .LSB_FIRST(1'b0)) u_dut_msb (
    .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_bus),
    .sda_oe(oe_b), .busy(busy_b), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .state(state_b)
  );

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];
  logic [11:0] exp_q_b[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  mem_a [16];
  logic [7:0]  mem_b [16];
  logic [3:0]  ptr_a, ptr_b;
  int          spur_a = 0, spur_b = 0;
  int          oe_hits = 0;
  logic        watch = 1'b0;
  logic        prev_wr_a = 1'b0, prev_wr_b = 1'b0;
  logic [11:0] e_a, e_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en_a) begin
      if (prev_wr_a || exp_q.size() == 0) spur_a++;
      else begin
        e_a = exp_q.pop_front();
        check("wr_a", {20'd0, wr_addr_a, wr_data_a}, {20'd0, e_a});
      end
    end
    prev_wr_a = wr_en_a;
    if (wr_en_b) begin
      if (prev_wr_b || exp_q_b.size() == 0) spur_b++;
      else begin
        e_b = exp_q_b.pop_front();
        check("wr_b", {20'd0, wr_addr_b, wr_data_b}, {20'd0, e_b});
      end
    end
    prev_wr_b = wr_en_b;
    if (watch && oe_a) oe_hits++;
  end

  task automatic push_wr_a(input logic [7:0] d);
    exp_q.push_back({ptr_a, d});
    mem_a[ptr_a] = d;
    ptr_a++;
  endtask

  task automatic push_wr_b(input logic [7:0] d);
    exp_q_b.push_back({ptr_b, d});
    mem_b[ptr_b] = d;
    ptr_b++;
  endtask

  task automatic push_rd_a();
    rd_q.push_back(mem_a[ptr_a]);
    ptr_a++;
  endtask

  task automatic push_rd_b();
    rd_q.push_back(mem_b[ptr_b]);
    ptr_b++;
  endtask

  function automatic logic [7:0] abyte(input logic [6:0] a, input bit rw, input bit lsb);
    return lsb ? {rw, a} : {a, rw};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_start();
    m_sda = 1'b1; #(Q);
    scl = 1'b1;   #(2*Q);
    m_sda = 1'b0; #(2*Q);
    scl = 1'b0;   #(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #(Q);
    scl = 1'b1;   #(2*Q);
    m_sda = 1'b1; #(2*Q);
  endtask

  task automatic send_bit(input bit b);
    m_sda = b; #(Q);
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #(Q);
  endtask

  task automatic tx_byte(input string tag, input logic [7:0] b, input bit lsb, input bit exp_ack);
    bit ack;
    for (int i = 0; i < 8; i++) send_bit(lsb ? b[i] : b[7-i]);
    m_sda = 1'b1; #(Q);
    scl = 1'b1;   #(Q);
    ack = ~sda_bus; #(Q);
    scl = 1'b0;   #(Q);
    check(tag, {31'd0, ack}, {31'd0, exp_ack});
  endtask

  task automatic rx_byte(input string tag, input bit lsb, input bit mack);
    logic [7:0] got;
    logic [7:0] exp_v;
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; #(Q);
      scl = 1'b1;   #(Q);
      if (lsb) got[i] = sda_bus;
      else     got[7-i] = sda_bus;
      #(Q);
      scl = 1'b0;   #(Q);
    end
    m_sda = ~mack; #(Q);
    scl = 1'b1;    #(2*Q);
    scl = 1'b0;    #(Q);
    exp_v = rd_q.pop_front();
    check(tag, {24'd0, got}, {24'd0, exp_v});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    scl   = 1'b1;
    m_sda = 1'b1;
    ptr_a = 4'h0;
    ptr_b = 4'h0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end

    #30;
    check("rst_oe",      {31'd0, oe_a},     0);
    check("rst_busy",    {31'd0, busy_a},   0);
    check("rst_wr_en",   {31'd0, wr_en_a},  0);
    check("rst_wr_addr", {28'd0, wr_addr_a}, 0);
    check("rst_wr_data", {24'd0, wr_data_a}, 0);
    check("rst_state",   {28'd0, state_a},  0);
    #50 reset = 1'b0;
    #(Q);

    // Basic write: pointer BD -> index D, one data byte.
    bus_start();
    check("t1_busy", {31'd0, busy_a}, 1);
    tx_byte("t1_addr_ack", abyte(7'h5B, 1'b0, 1'b1), 1'b1, 1'b1);
    ptr_a = 4'hD;
    tx_byte("t1_maddr_ack", 8'hBD, 1'b1, 1'b1);
    push_wr_a(8'hF4);
    tx_byte("t1_data_ack", 8'hF4, 1'b1, 1'b1);
    bus_stop();
    check("t1_busy_stop", {31'd0, busy_a}, 0);
    check("t1_state", {28'd0, state_a}, 0);
    check("t1_wr_pending", exp_q.size(), 0);

    // Set pointer, repeated START, read two bytes (ACK then NACK).
    bus_start();
    tx_byte("t2_addr_ack", abyte(7'h5B, 1'b0, 1'b1), 1'b1, 1'b1);
    ptr_a = 4'hD;
    tx_byte("t2_maddr_ack", 8'h0D, 1'b1, 1'b1);
    bus_start();
    tx_byte("t2_raddr_ack", abyte(7'h5B, 1'b1, 1'b1), 1'b1, 1'b1);
    push_rd_a();
    rx_byte("t2_rd0", 1'b1, 1'b1);
    push_rd_a();
    rx_byte("t2_rd1", 1'b1, 1'b0);
    check("t2_wait_stop", {28'd0, state_a}, 9);
    bus_stop();
    check("t2_idle", {28'd0, state_a}, 0);

    // Address mismatch: no ACK, no drive, no write.
    watch = 1'b1;
    bus_start();
    tx_byte("t3_addr_nack", abyte(7'h2A, 1'b0, 1'b1), 1'b1, 1'b0);
    check("t3_state_a", {28'd0, state_a}, 9);
    tx_byte("t3_b0_nack", 8'h01, 1'b1, 1'b0);
    tx_byte("t3_b1_nack", 8'h02, 1'b1, 1'b0);
    tx_byte("t3_b2_nack", 8'h03, 1'b1, 1'b0);
    check("t3_state_b", {28'd0, state_a}, 9);
    bus_stop();
    watch = 1'b0;
    check("t3_oe_hits", oe_hits, 0);
    check("t3_idle", {28'd0, state_a}, 0);
    check("t3_spurious", spur_a, 0);

    // Pointer wrap from F to 0, then read both back.
    bus_start();
    tx_byte("t4_addr_ack", abyte(7'h5B, 1'b0, 1'b1), 1'b1, 1'b1);
    ptr_a = 4'hF;
    tx_byte("t4_maddr_ack", 8'h0F, 1'b1, 1'b1);
    push_wr_a(8'h11);
    tx_byte("t4_d0_ack", 8'h11, 1'b1, 1'b1);
    push_wr_a(8'h22);
    tx_byte("t4_d1_ack", 8'h22, 1'b1, 1'b1);
    bus_stop();
    bus_start();
    tx_byte("t4_addr2_ack", abyte(7'h5B, 1'b0, 1'b1), 1'b1, 1'b1);
    ptr_a = 4'hF;
    tx_byte("t4_maddr2_ack", 8'h0F, 1'b1, 1'b1);
    bus_start();
    tx_byte("t4_raddr_ack", abyte(7'h5B, 1'b1, 1'b1), 1'b1, 1'b1);
    push_rd_a();
    rx_byte("t4_rd15", 1'b1, 1'b1);
    push_rd_a();
    rx_byte("t4_rd0", 1'b1, 1'b0);
    bus_stop();
    check("t4_wr_pending", exp_q.size(), 0);

    // Abort: STOP after 4 bits of a data byte.
    bus_start();
    tx_byte("t5_addr_ack", abyte(7'h5B, 1'b0, 1'b1), 1'b1, 1'b1);
    ptr_a = 4'h5;
    tx_byte("t5_maddr_ack", 8'h05, 1'b1, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    bus_stop();
    check("t5_idle", {28'd0, state_a}, 0);
    check("t5_spurious", spur_a, 0);

    // Reset while the target is driving the address ACK.
    bus_start();
    begin
      logic [7:0] ab;
      ab = abyte(7'h5B, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) send_bit(ab[i]);
    end
    m_sda = 1'b1; #(Q);
    scl = 1'b1;   #(Q);
    check("t6_ack_oe", {31'd0, oe_a}, 1);
    check("t6_ack_state", {28'd0, state_a}, 2);
    #3 reset = 1'b1;
    #1;
    check("t6_rst_oe", {31'd0, oe_a}, 0);
    check("t6_rst_state", {28'd0, state_a}, 0);
    check("t6_rst_busy", {31'd0, busy_a}, 0);
    #36 reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    ptr_a = 4'h0;
    ptr_b = 4'h0;
    #(Q);
    bus_start();
    tx_byte("t6_raddr_ack", abyte(7'h5B, 1'b1, 1'b1), 1'b1, 1'b1);
    push_rd_a();
    rx_byte("t6_rd0", 1'b1, 1'b1);
    push_rd_a();
    rx_byte("t6_rd1", 1'b1, 1'b0);
    bus_stop();
    bus_start();
    tx_byte("t6_addr_ack", abyte(7'h5B, 1'b0, 1'b1), 1'b1, 1'b1);
    ptr_a = 4'hD;
    tx_byte("t6_maddr_ack", 8'h0D, 1'b1, 1'b1);
    bus_start();
    tx_byte("t6_raddr2_ack", abyte(7'h5B, 1'b1, 1'b1), 1'b1, 1'b1);
    push_rd_a();
    rx_byte("t6_rd13", 1'b1, 1'b1);
    push_rd_a();
    rx_byte("t6_rd14", 1'b1, 1'b1);
    push_rd_a();
    rx_byte("t6_rd15", 1'b1, 1'b0);
    bus_stop();

    // MSB-first target: write A5 to index 3, read it back.
    bus_start();
    tx_byte("t7_addr_ack", abyte(7'h3C, 1'b0, 1'b0), 1'b0, 1'b1);
    ptr_b = 4'h3;
    tx_byte("t7_maddr_ack", 8'h03, 1'b0, 1'b1);
    push_wr_b(8'hA5);
    tx_byte("t7_data_ack", 8'hA5, 1'b0, 1'b1);
    bus_stop();
    bus_start();
    tx_byte("t7_addr2_ack", abyte(7'h3C, 1'b0, 1'b0), 1'b0, 1'b1);
    ptr_b = 4'h3;
    tx_byte("t7_maddr2_ack", 8'h03, 1'b0, 1'b1);
    bus_start();
    tx_byte("t7_raddr_ack", abyte(7'h3C, 1'b1, 1'b0), 1'b0, 1'b1);
    push_rd_b();
    rx_byte("t7_rd3", 1'b0, 1'b0);
    bus_stop();
    check("t7_wr_pending_b", exp_q_b.size(), 0);
    check("t7_spurious_a", spur_a, 0);
    check("t7_spurious_b", spur_b, 0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
